// File: rtl/display_pkg.sv
// Shared constants, state encodings and glyph helper for the VRAM write path.
package display_pkg;
  localparam int ROW_W   = 5;
  localparam int COL_W   = 6;
  localparam int VRAM_AW = 11;

  localparam logic [5:0] CHAR_SPACE = 6'd32;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] CR_HI = 8'h8D;
  localparam logic [7:0] NUL   = 8'h00;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] DEL   = 8'h7F;
  localparam logic [7:0] ESC   = 8'h9B;

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t S_IDLE   = 2'd0;
  localparam sched_state_t S_CHAR   = 2'd1;
  localparam sched_state_t S_SCROLL = 2'd2;
  localparam sched_state_t S_CLEAR  = 2'd3;

  function automatic logic [5:0] glyph(input logic [7:0] d);
    return {~d[6], d[4:0]};
  endfunction
endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU TX handshake plus the display RAM write port.
interface vram_write_scheduler_if;
  import display_pkg::*;
  logic               cpu_clken;
  logic               tx_we;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [VRAM_AW-1:0] vram_w_addr;
  logic [5:0]         vram_w_data;
  logic               vram_w_en;

  modport master (
    output cpu_clken, tx_we, tx_data,
    input  tx_ready, vram_w_addr, vram_w_data, vram_w_en
  );
  modport slave (
    input  cpu_clken, tx_we, tx_data,
    output tx_ready, vram_w_addr, vram_w_data, vram_w_en
  );
endinterface

// File: rtl/vram_write_scheduler_fifo.sv
// Show-ahead TX character FIFO with flush and look-ahead full flag.
module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       full_next
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  assign full_next = count_nxt == (AW+1)'(DEPTH);

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (do_push & ~flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/vram_write_scheduler.sv
// Owns the VRAM write port: decodes TX chars, scroll-clears a row, clears the screen.
module vram_write_scheduler
  import display_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 24
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic               pixel_clken,
  input  logic               clr_req,
  vram_write_scheduler_if.slave bus,
  output logic [VRAM_AW-1:0] cursor_addr,
  output logic [ROW_W-1:0]   start_row,
  output logic               busy
);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROWS_R   = ROW_W'(ROWS);

  sched_state_t     state;
  logic [ROW_W-1:0] cur_row, end_row, sw_row, nxt_row;
  logic [COL_W-1:0] cur_col, sw_col, nxt_col;
  logic [7:0]       char_q, fifo_dout;
  logic             fifo_full, fifo_empty, fifo_full_next;
  logic             push, pop, flush, clear_end, char_wr;
  logic             wr_en;
  logic [VRAM_AW-1:0] wr_addr;
  logic [5:0]       wr_data;

  assign push      = bus.tx_we & bus.cpu_clken & bus.tx_ready;
  assign clear_end = (sw_row == '1) && (sw_col == LAST_COL);
  assign pop       = pixel_clken & (state == S_IDLE) & ~clr_req
                   & (cur_row != end_row) & ~fifo_empty;
  assign flush     = pixel_clken & clr_req
                   & ((state != S_CLEAR) | clear_end);

  char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clock (sys_clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .din       (bus.tx_data),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  always_comb begin
    nxt_row = cur_row;
    nxt_col = cur_col;
    char_wr = 1'b0;
    unique case (1'b1)
      (char_q == CR) || (char_q == CR_HI): begin
        nxt_col = '0;
        nxt_row = cur_row + 1'b1;
      end
      (char_q == NUL) || (char_q == LF) ||
      (char_q == DEL) || (char_q == ESC): nxt_col = '0;
      default: begin
        char_wr = 1'b1;
        if (cur_col == LAST_COL) begin
          nxt_col = '0;
          nxt_row = cur_row + 1'b1;
        end else begin
          nxt_col = cur_col + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {cur_row, cur_col};
    wr_data = glyph(char_q);
    unique case (state)
      S_CHAR: wr_en = char_wr;
      S_SCROLL: begin
        wr_en   = 1'b1;
        wr_addr = {end_row, sw_col};
        wr_data = CHAR_SPACE;
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = {sw_row, sw_col};
        wr_data = CHAR_SPACE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      bus.vram_w_en   <= 1'b0;
      bus.vram_w_addr <= '0;
      bus.vram_w_data <= '0;
      bus.tx_ready    <= 1'b0;
    end else begin
      bus.tx_ready  <= ~fifo_full_next;
      bus.vram_w_en <= pixel_clken & wr_en;
      if (pixel_clken & wr_en) begin
        bus.vram_w_addr <= wr_addr;
        bus.vram_w_data <= wr_data;
      end
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_row   <= '0;
      cur_col   <= '0;
      start_row <= '0;
      end_row   <= ROWS_R;
      sw_row    <= '0;
      sw_col    <= '0;
      char_q    <= '0;
    end else if (pixel_clken) begin
      unique case (state)
        S_IDLE: begin
          if (clr_req) begin
            state <= S_CLEAR;
          end else if (cur_row == end_row) begin
            state <= S_SCROLL;
          end else if (!fifo_empty) begin
            state  <= S_CHAR;
            char_q <= fifo_dout;
          end
        end
        S_CHAR: begin
          cur_row <= nxt_row;
          cur_col <= nxt_col;
          if (clr_req)
            state <= S_CLEAR;
          else if (nxt_row == end_row)
            state <= S_SCROLL;
          else
            state <= S_IDLE;
        end
        S_SCROLL: begin
          sw_col <= sw_col + 1'b1;
          if (sw_col == LAST_COL) begin
            sw_col    <= '0;
            start_row <= start_row + 1'b1;
            end_row   <= end_row + 1'b1;
          end
          if (clr_req)
            state <= S_CLEAR;
          else if (sw_col == LAST_COL)
            state <= S_IDLE;
        end
        default: begin
          if (sw_col == LAST_COL) begin
            sw_col <= '0;
            sw_row <= sw_row + 1'b1;
          end else begin
            sw_col <= sw_col + 1'b1;
          end
          if (clear_end) begin
            cur_row   <= '0;
            cur_col   <= '0;
            start_row <= '0;
            end_row   <= ROWS_R;
            if (!clr_req) state <= S_IDLE;
          end
        end
      endcase
      // Every entry into a sweep starts from the screen origin.
      if (clr_req && state != S_CLEAR) begin
        sw_row  <= '0;
        sw_col  <= '0;
        cur_row <= '0;
        cur_col <= '0;
      end
    end
  end

  assign cursor_addr = {cur_row, cur_col};
  assign busy        = state != S_IDLE;
endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed self-checking bench for vram_write_scheduler.
module tb_vram_write_scheduler;
  logic        sys_clock = 1'b0;
  logic        reset;
  logic        pixel_clken;
  logic        clr_req;
  logic [10:0] cursor_addr;
  logic [4:0]  start_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [10:0] qa[$];
  logic [5:0]  qd[$];

  vram_write_scheduler_if bus();

  vram_write_scheduler #(
    .FIFO_DEPTH(4), .COLS(40), .ROWS(24)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .pixel_clken (pixel_clken),
    .clr_req     (clr_req),
    .bus         (bus),
    .cursor_addr (cursor_addr),
    .start_row   (start_row),
    .busy        (busy)
  );

  always #5 sys_clock = ~sys_clock;

  always @(negedge sys_clock) begin
    if (bus.vram_w_en === 1'b1) begin
      qa.push_back(bus.vram_w_addr);
      qd.push_back(bus.vram_w_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 500) begin
      @(negedge sys_clock);
      n++;
    end
    if (bus.tx_ready !== 1'b1) check("push_timeout", 32'(bus.tx_ready), 1);
    bus.tx_we   = 1'b1;
    bus.tx_data = b;
    @(negedge sys_clock);
    bus.tx_we   = 1'b0;
  endtask

  task automatic settle(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge sys_clock);
      n++;
      if (!busy && bus.vram_w_en !== 1'b1) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check(tag, 32'(quiet), 4);
  endtask

  initial begin
    int mism;
    int idx;
    logic [7:0]  b;
    logic [10:0] ea;
    logic [7:0]  hello [5];
    hello[0] = 8'hC8; hello[1] = 8'hC5; hello[2] = 8'hCC;
    hello[3] = 8'hCC; hello[4] = 8'hCF;

    reset = 1'b1;
    pixel_clken = 1'b1;
    clr_req = 1'b0;
    bus.cpu_clken = 1'b1;
    bus.tx_we = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge sys_clock);
    check("rst_tx_ready", 32'(bus.tx_ready), 0);
    check("rst_w_en", 32'(bus.vram_w_en), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (5) @(negedge sys_clock);
    check("idle_tx_ready", 32'(bus.tx_ready), 1);
    check("idle_no_writes", qa.size(), 0);
    check("idle_cursor", 32'(cursor_addr), 0);
    check("idle_start_row", 32'(start_row), 0);

    // single printable char
    push(8'hC1);
    settle("settle_c1", 100);
    check("c1_count", qa.size(), 1);
    if (qa.size() > 0) begin
      check("c1_addr", 32'(qa[0]), 32'h000);
      check("c1_data", 32'(qd[0]), 32'h01);
    end
    check("c1_cursor", 32'(cursor_addr), 32'h001);
    qa.delete(); qd.delete();

    // NUL returns the cursor to column 0 without writing
    push(8'h00);
    settle("settle_nul", 100);
    check("nul_no_write", qa.size(), 0);
    check("nul_cursor", 32'(cursor_addr), 32'h000);

    // full row of 40 printable characters
    for (int i = 0; i < 40; i++) begin
      b = 8'hC1 + 8'(i % 26);
      push(b);
    end
    settle("settle_row", 500);
    check("row_count", qa.size(), 40);
    mism = 0;
    foreach (qa[k]) begin
      if (qa[k] !== 11'(k) || qd[k] !== 6'((k % 26) + 1)) mism++;
    end
    check("row_seq", mism, 0);
    if (qa.size() > 0) check("row_last_addr", 32'(qa[qa.size()-1]), 32'h027);
    check("row_cursor", 32'(cursor_addr), 32'h040);
    qa.delete(); qd.delete();

    // CRs down to row 23
    for (int i = 0; i < 22; i++) push(8'h0D);
    settle("settle_cr", 500);
    check("cr_no_write", qa.size(), 0);
    check("cr_cursor", 32'(cursor_addr), 32'h5C0);

    // CR at row 23 hits end_row 24 and scroll-clears row 24
    push(8'h8D);
    settle("settle_scroll", 500);
    check("scroll_count", qa.size(), 40);
    mism = 0;
    foreach (qa[k]) begin
      if (qa[k] !== 11'(32'h600 + k) || qd[k] !== 6'd32) mism++;
    end
    check("scroll_seq", mism, 0);
    if (qa.size() > 0) begin
      check("scroll_first", 32'(qa[0]), 32'h600);
      check("scroll_last", 32'(qa[qa.size()-1]), 32'h627);
    end
    check("scroll_start_row", 32'(start_row), 1);
    check("scroll_cursor", 32'(cursor_addr), 32'h600);
    qa.delete(); qd.delete();

    // back-to-back pushes with the scheduler stalled
    pixel_clken = 1'b0;
    for (int i = 0; i < 4; i++) push(hello[i]);
    check("full_tx_ready", 32'(bus.tx_ready), 0);
    repeat (3) @(negedge sys_clock);
    check("full_tx_ready_hold", 32'(bus.tx_ready), 0);
    check("full_no_write", qa.size(), 0);
    pixel_clken = 1'b1;
    push(hello[4]);
    settle("settle_hello", 500);
    check("hello_count", qa.size(), 5);
    mism = 0;
    foreach (qa[k]) begin
      if (k < 5) begin
        if (qa[k] !== 11'(32'h600 + k) || qd[k] !== {1'b0, hello[k][4:0]})
          mism++;
      end
    end
    check("hello_seq", mism, 0);
    check("hello_cursor", 32'(cursor_addr), 32'h605);
    qa.delete(); qd.delete();

    // CR hits end_row 25; clear request lands mid-scroll
    push(8'h0D);
    idx = 0;
    while (qa.size() < 3 && idx < 200) begin
      @(negedge sys_clock);
      idx++;
    end
    check("scroll2_started", 32'(qa.size() >= 3), 1);
    push(8'hC1);
    push(8'hC2);
    clr_req = 1'b1;
    @(negedge sys_clock);
    clr_req = 1'b0;
    settle("settle_clear", 3000);
    repeat (20) @(negedge sys_clock);
    idx = qa.size();
    for (int k = qa.size() - 1; k >= 0; k--) begin
      if (qa[k] === 11'h000) idx = k;
    end
    check("partial_scroll", 32'(idx > 0 && idx < 40), 1);
    if (qa.size() > 0) check("partial_first", 32'(qa[0]), 32'h640);
    check("clear_count", qa.size() - idx, 1280);
    mism = 0;
    for (int k = 0; k < 1280; k++) begin
      ea = 11'(((k / 40) << 6) | (k % 40));
      if (idx + k >= qa.size()) mism++;
      else if (qa[idx+k] !== ea || qd[idx+k] !== 6'd32) mism++;
    end
    check("clear_seq", mism, 0);
    if (qa.size() > 0) check("clear_last", 32'(qa[qa.size()-1]), 32'h7E7);
    check("clear_cursor", 32'(cursor_addr), 0);
    check("clear_start_row", 32'(start_row), 0);
    check("clear_busy", 32'(busy), 0);
    check("clear_tx_ready", 32'(bus.tx_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
